// File: rtl/alu_pkg.sv
// Shared types for the ALU word sequencer: ALU opcodes and the sequencer FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB = 2'b00,
    OP_CMP = 2'b01,
    OP_SHL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences a multi-word operation through a single-word ALU, one word per cycle,
// and assembles the result, final carry and sticky error for a valid/ready consumer.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // Handshakes: a command is taken on an edge with i_valid && o_ready, a result is
  // consumed on an edge with o_valid && i_ready; neither side is queued.
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [WORDS*BITS-1:0] i_a,
  input  logic [WORDS*BITS-1:0] i_b,
  input  logic                  i_carry,
  output logic [BITS-1:0]       o_alu_a,
  output logic [BITS-1:0]       o_alu_b,
  output logic [1:0]            o_alu_op,
  output logic                  o_alu_carry,
  input  logic [BITS-1:0]       i_alu_out,
  input  logic                  i_alu_carry,
  input  logic                  i_alu_err,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WORDS*BITS-1:0] o_out,
  output logic                  o_carry,
  output logic                  o_err,
  output state_e                o_dbg_state
);

  localparam int W     = WORDS * BITS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  op_e              op_q, op_d;
  logic             chain_q, chain_d;
  logic [W-1:0]     out_q, out_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             last_word;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    chain_d     = chain_q;
    out_d       = out_q;
    carry_d     = carry_q;
    err_d       = err_q;
    last_word   = 1'b0;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_op    = '0;
    o_alu_carry = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          op_d    = op_e'(i_op);
          chain_d = i_carry;
          idx_d   = '0;
          out_d   = '0;
          carry_d = 1'b0;
          // Reserved opcode never touches the ALU and reports an error immediately.
          err_d   = (op_e'(i_op) == OP_RSV);
          state_d = (op_e'(i_op) == OP_RSV) ? DONE : RUN;
        end
      end
      RUN: begin
        o_alu_a     = a_q[int'(idx_q)*BITS +: BITS];
        o_alu_b     = b_q[int'(idx_q)*BITS +: BITS];
        o_alu_op    = op_q;
        o_alu_carry = chain_q;
        out_d[int'(idx_q)*BITS +: BITS] = i_alu_out;
        chain_d     = i_alu_carry;
        if (op_q == OP_SHL) err_d = err_q | i_alu_err;
        // Only SUB walks every word; CMP and SHL finish after word 0.
        last_word = (op_q != OP_SUB) || (idx_q == LAST_IDX);
        if (last_word) begin
          state_d = DONE;
          idx_d   = '0;
          carry_d = (op_q == OP_SUB) ? i_alu_carry : 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_SUB;
      chain_q <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      chain_q <= chain_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign o_out       = out_q;
  assign o_carry     = carry_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter BITS, default 8, ALU word width in bits.
REQ-002 Parameter WORDS, default 4, number of ALU words per operand; legal range is 2..16.
REQ-003 i_clk  input  1  clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  command valid.
REQ-006 o_ready  output  1  command accepted on an edge where i_valid && o_ready.
REQ-007 i_op  input  2  command opcode: 00 SUB, 01 CMP, 10 SHL, 11 reserved.
REQ-008 i_a, i_b  input  WORDS*BITS  operands; word 0 is bits [BITS-1:0].
REQ-009 i_carry  input  1  carry-in for SUB word 0.
REQ-010 o_alu_a, o_alu_b  output  BITS  current operand word driven to the ALU.
REQ-011 o_alu_op  output  2  opcode driven to the ALU.
REQ-012 o_alu_carry  output  1  carry driven to the ALU.
REQ-013 i_alu_out  input  BITS  ALU result, combinational from the o_alu_* outputs.
REQ-014 i_alu_carry, i_alu_err  input  1  ALU carry-out and error flag.
REQ-015 o_valid  output  1  result valid.
REQ-016 i_ready  input  1  result consumed on an edge where o_valid && i_ready.
REQ-017 o_out  output  WORDS*BITS  assembled result.
REQ-018 o_carry, o_err  output  1  final carry and sticky error.

Function
REQ-019 The FSM SHALL have three states, with these transitions:
- IDLE -> RUN on accept; operands, opcode and carry are latched and idx is set to 0.
- RUN -> DONE after the last ALU word is captured.
- DONE -> IDLE on result handshake.
REQ-020 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-021 In RUN the block SHALL drive o_alu_a and o_alu_b with latched word idx and o_alu_op with the latched opcode.
REQ-022 In RUN, each rising edge SHALL capture i_alu_out into result word idx, then increment idx.
REQ-023 SUB SHALL iterate idx 0..WORDS-1 with the carry chained between words:
- word 0 uses the latched i_carry.
- word n>0 uses i_alu_carry registered at word n-1.
REQ-024 o_carry SHALL equal i_alu_carry captured at word WORDS-1 for SUB, and 0 for CMP and SHL.
REQ-025 CMP and SHL SHALL run one ALU cycle on word 0 only; result words 1..WORDS-1 SHALL be 0.
REQ-026 o_err SHALL be the OR of i_alu_err over all captured words, for SHL only; it SHALL be 0 for SUB and CMP.
REQ-027 Opcode 11 SHALL be accepted and go directly IDLE -> DONE with o_out=0, o_carry=0 and o_err=1; no ALU cycle is issued.
REQ-028 Latency: o_valid SHALL rise after the WORDS-th rising edge following the accept edge for SUB, and after the 1st for CMP and SHL.
REQ-029 o_out, o_carry and o_err SHALL be stable while o_valid=1 and i_ready=0.
REQ-030 Outside RUN, o_alu_a, o_alu_b, o_alu_op and o_alu_carry SHALL be 0.
REQ-031 An i_valid that is high while not in IDLE SHALL be ignored, not queued.
REQ-032 idx SHALL wrap cleanly to 0 on leaving RUN; no out-of-range word is ever selected.
REQ-033 A result handshake and i_valid in the same cycle SHALL go DONE -> IDLE only; the new command is accepted on a later edge (throughput is one command per WORDS+2 cycles).

Reset
REQ-034 On i_rst=1 at a rising edge, state SHALL go to IDLE, idx to 0, and o_valid, o_out, o_carry, o_err and all o_alu_* outputs to 0.
REQ-035 Reset asserted mid-RUN or in DONE SHALL discard the command with no partial result presented.
REQ-036 o_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-037 i_rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-038 Shared package alu_pkg SHALL hold:
- the opcode enum (OP_SUB=2'b00, OP_CMP=2'b01, OP_SHL=2'b10, OP_RSV=2'b11);
- the FSM state typedef (IDLE, RUN, DONE).
REQ-039 No sub-module is required; the ALU is connected beside this block at the next level up, and word selection is an indexed part-select.

Verification
REQ-040 The bench SHALL cover these directed scenarios with BITS=8, WORDS=4 and the real ALU attached:
- SUB: A=0x00000100, B=0x00000001, carry=0 -> o_out=0x000000FF, o_carry=0, o_err=0; o_valid rises 4 edges after accept.
- SHL with an out-of-range shift amount (ALU raises its error flag on word 0), i_ready held low 5 cycles -> o_err=1, o_out[31:8]=0, outputs stable until the handshake.
- Opcode 11 -> o_valid after 1 edge, o_out=0, o_err=1, and the o_alu_* outputs stay 0 throughout.
- i_rst pulsed for 1 cycle during RUN idx=2 -> next cycle state is IDLE, o_valid=0, o_ready=1; the following SUB completes correctly.
- Back-to-back commands with i_valid held high and i_ready=1 -> exactly one accept per WORDS+2 cycles, no command lost or duplicated.
